// File: rtl/slc3_muldiv_unit_if.sv
// Request/response bundle between the ISDU/datapath and the multiply/divide unit.
// The master drives the operands and Start; the slave returns status and results.
interface slc3_muldiv_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Result_Hi;
  logic [WIDTH-1:0] Remainder;
  logic             Overflow;
  logic             Div_By_Zero;

  modport master (
    output Start, Op, A_in, B_in,
    input  Busy, Done, Result, Result_Hi, Remainder, Overflow, Div_By_Zero
  );

  modport slave (
    input  Start, Op, A_in, B_in,
    output Busy, Done, Result, Result_Hi, Remainder, Overflow, Div_By_Zero
  );
endinterface

// File: rtl/slc3_muldiv_unit.sv
// Iterative multiply/divide unit for the SLC-3 MUL/DIV opcodes: one shift-add or
// restoring shift-subtract step per cycle on magnitudes, sign fix-up in a final cycle.
module slc3_muldiv_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SIGNED = 1
) (
  input logic               Clk,
  input logic               Reset_n,
  slc3_muldiv_unit_if.slave bus
);
  localparam int unsigned      CntW    = $clog2(WIDTH);
  localparam bit               Sgn     = (SIGNED != 0);
  localparam logic [1:0]       StIdle  = 2'd0;
  localparam logic [1:0]       StCalc  = 2'd1;
  localparam logic [1:0]       StFix   = 2'd2;
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q;
  logic               op_q, sign_a_q, sign_b_q, zero_div_q;
  logic [WIDTH-1:0]   a_mag_q, b_mag_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH-1:0]   result_q, result_hi_q, remainder_q;
  logic               overflow_q, div_by_zero_q, done_q;

  logic               a_neg, b_neg, neg_res, fix_ovf;
  logic [WIDTH-1:0]   a_abs, b_abs, quot, rem, a_raw;
  logic [WIDTH-1:0]   fix_res, fix_hi, fix_rem;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] acc_step, prod;

  always_comb begin
    a_neg = Sgn & bus.A_in[WIDTH-1];
    b_neg = Sgn & bus.B_in[WIDTH-1];
    a_abs = a_neg ? -bus.A_in : bus.A_in;
    b_abs = b_neg ? -bus.B_in : bus.B_in;

    // MUL: right-shifting accumulator, multiplier consumed LSB-first from b_mag_q.
    // DIV: low half holds dividend bits shifting out and quotient bits shifting in.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_mag_q[0] ? {1'b0, a_mag_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag_q};
    if (op_q) begin
      acc_step = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end

    neg_res = sign_a_q ^ sign_b_q;
    prod    = neg_res ? -acc_q : acc_q;
    quot    = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    a_raw   = sign_a_q ? -a_mag_q : a_mag_q;

    if (zero_div_q) begin
      fix_res = '1;
      fix_hi  = '0;
      fix_rem = a_raw;
      fix_ovf = 1'b0;
    end else if (op_q) begin
      fix_res = quot;
      fix_hi  = '0;
      fix_rem = rem;
      // Only MIN / -1 overflows; the magnitude quotient already wraps to MIN.
      fix_ovf = sign_a_q & sign_b_q & (a_mag_q == MinNeg) & (b_mag_q == WIDTH'(1));
    end else begin
      fix_res = prod[WIDTH-1:0];
      fix_hi  = prod[2*WIDTH-1:WIDTH];
      fix_rem = '0;
      fix_ovf = Sgn ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                    : (prod[2*WIDTH-1:WIDTH] != '0);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= StIdle;
      op_q          <= 1'b0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      zero_div_q    <= 1'b0;
      a_mag_q       <= '0;
      b_mag_q       <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      result_hi_q   <= '0;
      remainder_q   <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.Start) begin
            op_q          <= bus.Op;
            sign_a_q      <= a_neg;
            sign_b_q      <= b_neg;
            a_mag_q       <= a_abs;
            b_mag_q       <= b_abs;
            acc_q         <= bus.Op ? {{WIDTH{1'b0}}, a_abs} : '0;
            cnt_q         <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            zero_div_q    <= bus.Op & (bus.B_in == '0);
            state_q       <= (bus.Op && bus.B_in == '0) ? StFix : StCalc;
          end
        end
        StCalc: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CntW'(1);
          if (!op_q) b_mag_q <= b_mag_q >> 1;
          if (cnt_q == LastCnt) state_q <= StFix;
        end
        StFix: begin
          result_q      <= fix_res;
          result_hi_q   <= fix_hi;
          remainder_q   <= fix_rem;
          overflow_q    <= fix_ovf;
          div_by_zero_q <= zero_div_q;
          done_q        <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Busy        = (state_q != StIdle);
  assign bus.Done        = done_q;
  assign bus.Result      = result_q;
  assign bus.Result_Hi   = result_hi_q;
  assign bus.Remainder   = remainder_q;
  assign bus.Overflow    = overflow_q;
  assign bus.Div_By_Zero = div_by_zero_q;
endmodule

// File: tb/tb_slc3_muldiv_unit.sv
// Bench for slc3_muldiv_unit: a signed and an unsigned 16-bit instance checked against
// an integer-arithmetic reference model, plus directed corner and control scenarios.
module tb_slc3_muldiv_unit;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vec   = 0;
  int   errs  = 0;

  always #5 clk = ~clk;

  slc3_muldiv_unit_if #(.WIDTH(16)) s_if ();
  slc3_muldiv_unit_if #(.WIDTH(16)) u_if ();

  slc3_muldiv_unit #(.WIDTH(16), .SIGNED(1)) u_dut_s (.Clk(clk), .Reset_n(rst_n), .bus(s_if));
  slc3_muldiv_unit #(.WIDTH(16), .SIGNED(0)) u_dut_u (.Clk(clk), .Reset_n(rst_n), .bus(u_if));

  // {Result, Result_Hi, Remainder, Overflow, Div_By_Zero}
  function automatic logic [49:0] model(input bit uns, input bit op,
                                        input logic [15:0] a, input logic [15:0] b);
    longint x, y, p, q, r;
    logic [63:0] pv, qv, rv;
    logic ovf;
    x = uns ? longint'(a) : longint'($signed(a));
    y = uns ? longint'(b) : longint'($signed(b));
    if (!op) begin
      p   = x * y;
      pv  = p;
      ovf = uns ? (p > 65535) : (p < -32768 || p > 32767);
      return {pv[15:0], pv[31:16], 16'h0000, ovf, 1'b0};
    end
    if (y == 0) return {16'hFFFF, 16'h0000, a, 1'b0, 1'b1};
    if (!uns && x == -32768 && y == -1) return {16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    q  = x / y;
    r  = x % y;
    qv = q;
    rv = r;
    return {qv[15:0], 16'h0000, rv[15:0], 1'b0, 1'b0};
  endfunction

  function automatic logic [49:0] obs(input bit uns);
    if (uns) return {u_if.Result, u_if.Result_Hi, u_if.Remainder, u_if.Overflow, u_if.Div_By_Zero};
    return {s_if.Result, s_if.Result_Hi, s_if.Remainder, s_if.Overflow, s_if.Div_By_Zero};
  endfunction

  function automatic logic done_of(input bit uns);
    return uns ? u_if.Done : s_if.Done;
  endfunction

  function automatic logic busy_of(input bit uns);
    return uns ? u_if.Busy : s_if.Busy;
  endfunction

  task automatic drive(input bit uns, input bit st, input bit op,
                       input logic [15:0] a, input logic [15:0] b);
    if (uns) begin
      u_if.Start = st; u_if.Op = op; u_if.A_in = a; u_if.B_in = b;
    end else begin
      s_if.Start = st; s_if.Op = op; s_if.A_in = a; s_if.B_in = b;
    end
  endtask

  // lat = clock edges from the accept edge to the edge that raised Done.
  task automatic run_op(input bit uns, input bit op, input logic [15:0] a, input logic [15:0] b,
                        output logic [49:0] o, output int lat, output int busy_n);
    @(negedge clk);
    drive(uns, 1'b1, op, a, b);
    @(negedge clk);
    drive(uns, 1'b0, ~op, 16'($urandom), 16'($urandom));
    lat    = 0;
    busy_n = 0;
    while (!done_of(uns) && lat < 60) begin
      if (busy_of(uns)) busy_n++;
      @(negedge clk);
      lat++;
    end
    o = obs(uns);
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    vec++;
    if ({busy_of(0), done_of(0), obs(0)} !== 52'h0) begin
      $display("FAIL reset_signed: got %h want 0", {busy_of(0), done_of(0), obs(0)});
      errs++;
    end
    vec++;
    if ({busy_of(1), done_of(1), obs(1)} !== 52'h0) begin
      $display("FAIL reset_unsigned: got %h want 0", {busy_of(1), done_of(1), obs(1)});
      errs++;
    end
  endtask

  task automatic test_directed();
    logic [83:0] tab [7];
    logic [83:0] t;
    logic [49:0] o;
    int lat, busy_n, exp_lat;
    // {uns, op, A, B, Result, Result_Hi, Remainder, Overflow, Div_By_Zero}
    tab = '{
      {1'b0, 1'b0, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 16'h0000, 1'b0, 1'b0},
      {1'b0, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'h0000, 16'hFFFF, 1'b0, 1'b0},
      {1'b0, 1'b1, 16'h0005, 16'h0000, 16'hFFFF, 16'h0000, 16'h0005, 1'b0, 1'b1},
      {1'b0, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b0},
      {1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b0},
      {1'b1, 1'b0, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0001, 16'h0000, 1'b1, 1'b0},
      {1'b1, 1'b1, 16'hFFFF, 16'h0010, 16'h0FFF, 16'h0000, 16'h000F, 1'b0, 1'b0}
    };
    for (int i = 0; i < 7; i++) begin
      t = tab[i];
      run_op(t[83], t[82], t[81:66], t[65:50], o, lat, busy_n);
      exp_lat = (t[82] && t[65:50] == 16'h0) ? 1 : 17;
      vec++;
      if (o !== t[49:0]) begin
        $display("FAIL directed_%0d: got %h want %h", i, o, t[49:0]);
        errs++;
      end
      vec++;
      if (lat !== exp_lat) begin
        $display("FAIL directed_lat_%0d: got %0d want %0d", i, lat, exp_lat);
        errs++;
      end
      vec++;
      if (busy_n !== exp_lat) begin
        $display("FAIL directed_busy_%0d: got %0d want %0d", i, busy_n, exp_lat);
        errs++;
      end
    end
  endtask

  task automatic test_random(input bit uns, input int n);
    logic [15:0] a, b;
    logic [49:0] o, e;
    bit op;
    int lat, busy_n, exp_lat;
    for (int i = 0; i < n; i++) begin
      a  = pick16();
      b  = pick16();
      op = 1'($urandom);
      e  = model(uns, op, a, b);
      exp_lat = (op && b == 16'h0) ? 1 : 17;
      run_op(uns, op, a, b, o, lat, busy_n);
      vec++;
      if (o !== e || lat !== exp_lat) begin
        $display("FAIL random_%s op=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                 uns ? "u" : "s", op, a, b, o, lat, e, exp_lat);
        errs++;
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [15:0] a, b;
    logic [49:0] e;
    int lat;
    a = 16'($urandom);
    b = 16'($urandom);
    e = model(1'b0, 1'b0, a, b);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, a, b);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    lat = 0;
    repeat (4) begin @(negedge clk); lat++; end
    drive(1'b0, 1'b1, 1'b1, ~a, 16'h0000);
    @(negedge clk);
    lat++;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    while (!done_of(0) && lat < 60) begin @(negedge clk); lat++; end
    vec++;
    if (obs(0) !== e || lat !== 17) begin
      $display("FAIL start_ignored: got %h lat %0d want %h lat 17", obs(0), lat, e);
      errs++;
    end
    @(negedge clk);
    vec++;
    if (busy_of(0) !== 1'b0 || done_of(0) !== 1'b0) begin
      $display("FAIL start_ignored_idle: got busy %b done %b want 0 0", busy_of(0), done_of(0));
      errs++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, b1, a2, b2;
    logic [49:0] e1, e2;
    int lat;
    a1 = 16'($urandom);
    b1 = 16'($urandom) | 16'h0001;
    a2 = 16'($urandom);
    b2 = 16'($urandom);
    e1 = model(1'b0, 1'b1, a1, b1);
    e2 = model(1'b0, 1'b0, a2, b2);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, a1, b1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, a2, b2);  // Start stays high through the first operation
    lat = 0;
    while (!done_of(0) && lat < 60) begin @(negedge clk); lat++; end
    vec++;
    if (obs(0) !== e1 || lat !== 17) begin
      $display("FAIL b2b_first: got %h lat %0d want %h lat 17", obs(0), lat, e1);
      errs++;
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    vec++;
    if (busy_of(0) !== 1'b1) begin
      $display("FAIL b2b_accept: got busy %b want 1", busy_of(0));
      errs++;
    end
    lat = 0;
    while (!done_of(0) && lat < 60) begin @(negedge clk); lat++; end
    vec++;
    if (obs(0) !== e2 || lat !== 17) begin
      $display("FAIL b2b_second: got %h lat %0d want %h lat 17", obs(0), lat, e2);
      errs++;
    end
  endtask

  task automatic test_reset_mid();
    logic [49:0] o, e;
    int lat, busy_n;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h1234, 16'h0567);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({busy_of(0), done_of(0), obs(0)} !== 52'h0) begin
      $display("FAIL reset_mid_s: got %h want 0", {busy_of(0), done_of(0), obs(0)});
      errs++;
    end
    vec++;
    if ({busy_of(1), done_of(1), obs(1)} !== 52'h0) begin
      $display("FAIL reset_mid_u: got %h want 0", {busy_of(1), done_of(1), obs(1)});
      errs++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = model(1'b0, 1'b1, 16'hFF00, 16'h0007);
    run_op(1'b0, 1'b1, 16'hFF00, 16'h0007, o, lat, busy_n);
    vec++;
    if (o !== e || lat !== 17) begin
      $display("FAIL reset_mid_after: got %h lat %0d want %h lat 17", o, lat, e);
      errs++;
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_directed();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
